// File: rtl/wb_port_arbiter_pkg.sv
// Shared types and constants for the register-file write-port arbiter.
// Holds the register index width, the write-source encoding and the default data width.
package wb_port_arbiter_pkg;

  localparam int unsigned REG_IDX_W = 5;
  localparam int unsigned DEF_DATA_WIDTH = 32;

  // Which requester owns the write port this cycle.
  typedef enum logic [1:0] {
    WB_SRC_NONE   = 2'd0,
    WB_SRC_PIPE   = 2'd1,
    WB_SRC_BUF    = 2'd2,
    WB_SRC_BYPASS = 2'd3
  } wb_src_e;

endpackage

// File: rtl/wb_buf_fifo.sv
// Synchronous DEPTH-entry FIFO of {rd, data} for buffered LLU results.
// Exposes per-entry rd/valid so the hazard compare can see every pending write.
module wb_buf_fifo
  import wb_port_arbiter_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int unsigned DEPTH      = 2,
  localparam int unsigned CntW      = $clog2(DEPTH + 1),
  localparam int unsigned PtrW      = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic                              push,
  input  logic [REG_IDX_W-1:0]              push_rd,
  input  logic [DATA_WIDTH-1:0]             push_data,
  input  logic                              pop,
  output logic [REG_IDX_W-1:0]              head_rd,
  output logic [DATA_WIDTH-1:0]             head_data,
  output logic [CntW-1:0]                   count,
  output logic [DEPTH-1:0]                  ent_valid,
  output logic [DEPTH-1:0][REG_IDX_W-1:0]   ent_rd
);

  logic [REG_IDX_W-1:0]  rd_q   [DEPTH];
  logic [DATA_WIDTH-1:0] data_q [DEPTH];
  logic [DEPTH-1:0]      valid_q;
  logic [PtrW-1:0]       wr_ptr_q, rd_ptr_q;
  logic [CntW-1:0]       count_q;

  function automatic logic [PtrW-1:0] ptr_inc(input logic [PtrW-1:0] ptr);
    return (ptr == PtrW'(DEPTH - 1)) ? '0 : ptr + PtrW'(1);
  endfunction

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      valid_q  <= '0;
    end else begin
      if (push) begin
        rd_q[wr_ptr_q]    <= push_rd;
        data_q[wr_ptr_q]  <= push_data;
        valid_q[wr_ptr_q] <= 1'b1;
        wr_ptr_q          <= ptr_inc(wr_ptr_q);
      end
      // Push and pop never hit the same slot: push needs room, pop needs an entry.
      if (pop) begin
        valid_q[rd_ptr_q] <= 1'b0;
        rd_ptr_q          <= ptr_inc(rd_ptr_q);
      end
      unique case ({push, pop})
        2'b10:   count_q <= count_q + CntW'(1);
        2'b01:   count_q <= count_q - CntW'(1);
        default: count_q <= count_q;
      endcase
    end
  end

  always_comb begin
    head_rd   = rd_q[rd_ptr_q];
    head_data = data_q[rd_ptr_q];
    count     = count_q;
    ent_valid = valid_q;
    for (int i = 0; i < DEPTH; i++) begin
      ent_rd[i] = rd_q[i];
    end
  end

endmodule

// File: rtl/wb_port_arbiter.sv
// Arbitrates the single register-file write port between pipeline writeback and the LLU,
// with a result buffer, starvation-forced WB bubbles and a pending-write hazard query.
module wb_port_arbiter
  import wb_port_arbiter_pkg::*;
#(
  parameter int unsigned DATA_WIDTH   = DEF_DATA_WIDTH,
  parameter int unsigned DEPTH        = 2,
  parameter int unsigned STARVE_LIMIT = 4,
  localparam int unsigned CntW        = $clog2(DEPTH + 1)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  pipe_we,
  input  logic [REG_IDX_W-1:0]  pipe_rd,
  input  logic [DATA_WIDTH-1:0] pipe_wdata,
  input  logic                  llu_valid,
  input  logic [REG_IDX_W-1:0]  llu_rd,
  input  logic [DATA_WIDTH-1:0] llu_wdata,
  output logic                  llu_ready,
  output logic                  rf_we,
  output logic [REG_IDX_W-1:0]  rf_waddr,
  output logic [DATA_WIDTH-1:0] rf_wdata,
  output logic                  pipe_stall,
  input  logic [REG_IDX_W-1:0]  hz_rs1,
  input  logic [REG_IDX_W-1:0]  hz_rs2,
  input  logic [REG_IDX_W-1:0]  hz_rd,
  output logic                  hz_hit,
  output logic [CntW-1:0]       buf_count
);

  localparam int unsigned StW = $clog2(STARVE_LIMIT + 1);
  localparam logic [StW-1:0]  StarveMax = StW'(STARVE_LIMIT);
  localparam logic [CntW-1:0] DepthCnt  = CntW'(DEPTH);

  logic [StW-1:0]                 starve_q, starve_d;
  wb_src_e                        src;
  logic                           llu_xfer, push, pop, buf_empty;
  logic [REG_IDX_W-1:0]           head_rd;
  logic [DATA_WIDTH-1:0]          head_data;
  logic [DEPTH-1:0]               ent_valid;
  logic [DEPTH-1:0][REG_IDX_W-1:0] ent_rd;

  wb_buf_fifo #(
    .DATA_WIDTH (DATA_WIDTH),
    .DEPTH      (DEPTH)
  ) u_buf (
    .clk       (clk),
    .rst       (rst),
    .push      (push),
    .push_rd   (llu_rd),
    .push_data (llu_wdata),
    .pop       (pop),
    .head_rd   (head_rd),
    .head_data (head_data),
    .count     (buf_count),
    .ent_valid (ent_valid),
    .ent_rd    (ent_rd)
  );

  assign buf_empty = (buf_count == '0);

  always_comb begin
    // Ready depends only on registered occupancy, never on this cycle's drain.
    llu_ready  = !rst && (buf_count < DepthCnt);
    pipe_stall = !rst && (starve_q == StarveMax);
    llu_xfer   = llu_valid && llu_ready;

    src = WB_SRC_NONE;
    if (!rst) begin
      if (!pipe_stall && pipe_we && (pipe_rd != '0)) begin
        src = WB_SRC_PIPE;
      end else if (!buf_empty) begin
        src = WB_SRC_BUF;
      end else if (llu_xfer && (llu_rd != '0)) begin
        src = WB_SRC_BYPASS;
      end
    end

    pop  = (src == WB_SRC_BUF);
    push = llu_xfer && (llu_rd != '0) && (src != WB_SRC_BYPASS);

    rf_we    = 1'b0;
    rf_waddr = '0;
    rf_wdata = '0;
    unique case (src)
      WB_SRC_PIPE: begin
        rf_we    = 1'b1;
        rf_waddr = pipe_rd;
        rf_wdata = pipe_wdata;
      end
      WB_SRC_BUF: begin
        rf_we    = 1'b1;
        rf_waddr = head_rd;
        rf_wdata = head_data;
      end
      WB_SRC_BYPASS: begin
        rf_we    = 1'b1;
        rf_waddr = llu_rd;
        rf_wdata = llu_wdata;
      end
      default: ;
    endcase
  end

  always_comb begin
    starve_d = starve_q;
    if (pop || buf_empty) begin
      starve_d = '0;
    end else if (starve_q != StarveMax) begin
      starve_d = starve_q + StW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      starve_q <= '0;
    end else begin
      starve_q <= starve_d;
    end
  end

  // x0 never hits; buffered entries and an in-flight LLU result both count as pending.
  always_comb begin
    hz_hit = 1'b0;
    if (!rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        if (ent_valid[i] && (ent_rd[i] != '0) &&
            (ent_rd[i] == hz_rs1 || ent_rd[i] == hz_rs2 || ent_rd[i] == hz_rd)) begin
          hz_hit = 1'b1;
        end
      end
      if (llu_valid && (llu_rd != '0) &&
          (llu_rd == hz_rs1 || llu_rd == hz_rs2 || llu_rd == hz_rd)) begin
        hz_hit = 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_wb_port_arbiter.sv
// Directed self-checking bench for wb_port_arbiter with hand-computed expectations.
module tb_wb_port_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        pipe_we;
  logic [4:0]  pipe_rd;
  logic [31:0] pipe_wdata;
  logic        llu_valid;
  logic [4:0]  llu_rd;
  logic [31:0] llu_wdata;
  logic        llu_ready;
  logic        rf_we;
  logic [4:0]  rf_waddr;
  logic [31:0] rf_wdata;
  logic        pipe_stall;
  logic [4:0]  hz_rs1, hz_rs2, hz_rd;
  logic        hz_hit;
  logic [1:0]  buf_count;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  wb_port_arbiter #(
    .DATA_WIDTH   (32),
    .DEPTH        (2),
    .STARVE_LIMIT (4)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .pipe_we    (pipe_we),
    .pipe_rd    (pipe_rd),
    .pipe_wdata (pipe_wdata),
    .llu_valid  (llu_valid),
    .llu_rd     (llu_rd),
    .llu_wdata  (llu_wdata),
    .llu_ready  (llu_ready),
    .rf_we      (rf_we),
    .rf_waddr   (rf_waddr),
    .rf_wdata   (rf_wdata),
    .pipe_stall (pipe_stall),
    .hz_rs1     (hz_rs1),
    .hz_rs2     (hz_rs2),
    .hz_rd      (hz_rd),
    .hz_hit     (hz_hit),
    .buf_count  (buf_count)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Advance past the next rising edge; inputs change and outputs are sampled off-edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  initial begin
    rst = 1'b1; pipe_we = 1'b0; pipe_rd = '0; pipe_wdata = '0;
    llu_valid = 1'b0; llu_rd = '0; llu_wdata = '0;
    hz_rs1 = '0; hz_rs2 = '0; hz_rd = '0;
    tick();
    tick();

    // Outputs forced quiet while reset is held, even with active requests.
    pipe_we = 1'b1; pipe_rd = 5'd5; llu_valid = 1'b1; llu_rd = 5'd7; hz_rd = 5'd7;
    settle();
    chk("rst_rf_we", 32'(rf_we), 32'd0);
    chk("rst_ready", 32'(llu_ready), 32'd0);
    chk("rst_stall", 32'(pipe_stall), 32'd0);
    chk("rst_hz", 32'(hz_hit), 32'd0);
    chk("rst_waddr", 32'(rf_waddr), 32'd0);
    chk("rst_count", 32'(buf_count), 32'd0);
    tick();
    rst = 1'b0; pipe_we = 1'b0; pipe_rd = '0; llu_valid = 1'b0; llu_rd = '0; hz_rd = '0;

    // Pipeline write, zero latency.
    pipe_we = 1'b1; pipe_rd = 5'd5; pipe_wdata = 32'hDEADBEEF;
    settle();
    chk("pipe_we", 32'(rf_we), 32'd1);
    chk("pipe_addr", 32'(rf_waddr), 32'd5);
    chk("pipe_data", rf_wdata, 32'hDEADBEEF);
    tick();
    chk("pipe_count", 32'(buf_count), 32'd0);

    // LLU bypass into an idle write port.
    pipe_we = 1'b0; pipe_rd = '0;
    llu_valid = 1'b1; llu_rd = 5'd7; llu_wdata = 32'h12;
    settle();
    chk("byp_ready", 32'(llu_ready), 32'd1);
    chk("byp_we", 32'(rf_we), 32'd1);
    chk("byp_addr", 32'(rf_waddr), 32'd7);
    chk("byp_data", rf_wdata, 32'h12);
    tick();
    chk("byp_count", 32'(buf_count), 32'd0);

    // rd=0 result: accepted and dropped.
    llu_rd = 5'd0; llu_wdata = 32'h55;
    settle();
    chk("x0_ready", 32'(llu_ready), 32'd1);
    chk("x0_we", 32'(rf_we), 32'd0);
    tick();
    chk("x0_count", 32'(buf_count), 32'd0);

    // Pipe busy every cycle: buffer fills, starvation forces two bubbles.
    pipe_we = 1'b1; pipe_rd = 5'd10; pipe_wdata = 32'hA;
    llu_rd = 5'd3; llu_wdata = 32'h33;
    settle();
    chk("fill0_addr", 32'(rf_waddr), 32'd10);
    tick();
    chk("fill1_count", 32'(buf_count), 32'd1);
    llu_rd = 5'd4; llu_wdata = 32'h44;
    settle();
    chk("fill1_ready", 32'(llu_ready), 32'd1);
    chk("fill1_stall", 32'(pipe_stall), 32'd0);
    tick();
    llu_valid = 1'b0; llu_rd = '0;
    chk("fill2_count", 32'(buf_count), 32'd2);
    chk("fill2_ready", 32'(llu_ready), 32'd0);
    hz_rs2 = 5'd3;
    settle();
    chk("fill2_hz", 32'(hz_hit), 32'd1);
    hz_rs2 = '0;
    for (int i = 2; i <= 4; i++) begin
      settle();
      chk("starve_wait1", 32'(pipe_stall), 32'd0);
      chk("starve_wait1_addr", 32'(rf_waddr), 32'd10);
      tick();
    end
    chk("stall1", 32'(pipe_stall), 32'd1);
    chk("stall1_addr", 32'(rf_waddr), 32'd3);
    chk("stall1_data", rf_wdata, 32'h33);
    tick();
    chk("stall1_count", 32'(buf_count), 32'd1);
    for (int i = 6; i <= 9; i++) begin
      chk("starve_wait2", 32'(pipe_stall), 32'd0);
      chk("starve_wait2_addr", 32'(rf_waddr), 32'd10);
      tick();
    end
    chk("stall2", 32'(pipe_stall), 32'd1);
    chk("stall2_addr", 32'(rf_waddr), 32'd4);
    chk("stall2_data", rf_wdata, 32'h44);
    tick();
    chk("stall2_count", 32'(buf_count), 32'd0);
    chk("post_stall", 32'(pipe_stall), 32'd0);
    chk("post_addr", 32'(rf_waddr), 32'd10);

    // Hazard query against a buffered x9.
    llu_valid = 1'b1; llu_rd = 5'd9; llu_wdata = 32'h99;
    tick();
    llu_valid = 1'b0; llu_rd = '0;
    hz_rs2 = 5'd9;
    settle();
    chk("hz_buf_hit", 32'(hz_hit), 32'd1);
    hz_rs2 = 5'd0; hz_rs1 = 5'd0; hz_rd = 5'd8;
    settle();
    chk("hz_nomatch", 32'(hz_hit), 32'd0);
    hz_rd = 5'd0;
    settle();
    chk("hz_x0", 32'(hz_hit), 32'd0);
    hz_rs2 = 5'd9; pipe_we = 1'b0;
    settle();
    chk("hz_drain_hit", 32'(hz_hit), 32'd1);
    chk("hz_drain_addr", 32'(rf_waddr), 32'd9);
    tick();
    chk("hz_after", 32'(hz_hit), 32'd0);
    chk("hz_after_count", 32'(buf_count), 32'd0);
    llu_valid = 1'b1; llu_rd = 5'd12; hz_rs2 = 5'd0; hz_rd = 5'd12;
    settle();
    chk("hz_llu_hit", 32'(hz_hit), 32'd1);
    tick();
    llu_valid = 1'b0; llu_rd = '0; hz_rd = '0;

    // Fill both entries, then reset mid-operation.
    pipe_we = 1'b1; pipe_rd = 5'd10;
    llu_valid = 1'b1; llu_rd = 5'd20; llu_wdata = 32'h20;
    tick();
    llu_rd = 5'd21; llu_wdata = 32'h21;
    tick();
    llu_valid = 1'b0; llu_rd = '0;
    chk("rst2_full", 32'(buf_count), 32'd2);
    rst = 1'b1;
    settle();
    chk("rst2_we", 32'(rf_we), 32'd0);
    chk("rst2_stall", 32'(pipe_stall), 32'd0);
    tick();
    rst = 1'b0; pipe_we = 1'b0; pipe_rd = '0;
    settle();
    chk("rst2_count", 32'(buf_count), 32'd0);
    chk("rst2_we_after", 32'(rf_we), 32'd0);
    chk("rst2_stall_after", 32'(pipe_stall), 32'd0);
    tick();
    chk("rst2_we_later", 32'(rf_we), 32'd0);
    chk("rst2_ready", 32'(llu_ready), 32'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
